// File: rtl/waterfall_pkg.sv
// waterfall_pkg: shared FSM states, default sizing and the magnitude estimator
package waterfall_pkg;
    typedef enum logic {IDLE, FRAME} state_t;
    localparam int DEF_BINS_LOG2 = 9;
    localparam int DEF_AVG_LOG2  = 2;
    function automatic logic [15:0] abs16(input logic [15:0] x);
        return x[15] ? 16'(~x + 16'd1) : x;
    endfunction
    // alpha-max-plus-beta-min with alpha=1, beta=1/2; peaks at 49152
    function automatic logic [15:0] mag(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a + (b >> 1) : b + (a >> 1);
    endfunction
endpackage

// File: rtl/bin_accum_ram.sv
// bin_accum_ram: simple dual-port RAM, one write port and a registered read port
module bin_accum_ram #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH = 18
) (
    input  logic                  clk_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk_data) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/waterfall_bin_averager.sv
// waterfall_bin_averager: FFT bins to magnitudes, averaged over 2^AVG_LOG2 spectra per column
module waterfall_bin_averager
    import waterfall_pkg::*;
#(
    parameter int BINS_LOG2 = DEF_BINS_LOG2,
    parameter int AVG_LOG2  = DEF_AVG_LOG2
) (
    input  logic               clk_data,
    input  logic               reset,
    input  logic               fft_valid,
    input  logic               fft_sop,
    input  logic               fft_eop,
    input  logic signed [15:0] fft_real,
    input  logic signed [15:0] fft_imag,
    output logic               sink_valid,
    output logic               sink_sop,
    output logic               sink_eop,
    output logic [15:0]        sink_data,
    output logic [7:0]         drop_count
);
    localparam int GW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int AW = 16 + AVG_LOG2;
    localparam logic [BINS_LOG2-1:0] LAST_BIN = '1;
    localparam logic [GW-1:0] LAST_G = GW'((1 << AVG_LOG2) - 1);

    state_t state, state_d;
    logic [BINS_LOG2-1:0] idx, idx_d, bin;
    logic [GW-1:0] g, g_d, samp_g;
    logic take, abort;

    always_ff @(posedge clk_data) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            g <= '0;
        end else begin
            state <= state_d;
            idx <= idx_d;
            g <= g_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d = idx;
        g_d = g;
        bin = idx;
        take = 1'b0;
        abort = 1'b0;
        if (fft_valid) begin
            if (fft_sop) begin
                abort = state == FRAME;
                take = 1'b1;
                bin = '0;
                idx_d = BINS_LOG2'(1);
                state_d = FRAME;
                g_d = abort ? '0 : g;
            end else if (state == FRAME) begin
                if (idx == LAST_BIN && fft_eop) begin
                    take = 1'b1;
                    state_d = IDLE;
                    g_d = (g == LAST_G) ? '0 : g + 1'b1;
                end else if (idx == LAST_BIN || fft_eop) begin
                    abort = 1'b1;
                    state_d = IDLE;
                    g_d = '0;
                end else begin
                    take = 1'b1;
                    idx_d = idx + 1'b1;
                end
            end
        end
    end

    // a sop that aborts a frame opens bin 0 of a fresh group
    assign samp_g = abort ? '0 : g;

    logic p0_v, p1_v, p2_v;
    logic p0_first, p1_first, p2_first, p0_last, p1_last, p2_last;
    logic [BINS_LOG2-1:0] p0_bin, p1_bin, p2_bin;
    logic [15:0] p0_re, p0_im, p1_a, p1_b, p2_mag;
    logic [AW-1:0] acc, sum;

    always_ff @(posedge clk_data) begin
        if (reset) begin
            p0_v <= 1'b0;
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            sink_valid <= 1'b0;
            sink_sop <= 1'b0;
            sink_eop <= 1'b0;
            sink_data <= '0;
            drop_count <= '0;
        end else begin
            p0_v <= take;
            p1_v <= p0_v;
            p2_v <= p1_v;
            sink_valid <= p2_v && p2_last;
            sink_sop <= p2_v && p2_last && p2_bin == '0;
            sink_eop <= p2_v && p2_last && p2_bin == LAST_BIN;
            sink_data <= (p2_v && p2_last) ? 16'(sum >> AVG_LOG2) : sink_data;
            drop_count <= (abort && drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
        end
    end

    always_ff @(posedge clk_data) begin
        p0_bin <= bin;
        p0_first <= samp_g == '0;
        p0_last <= samp_g == LAST_G;
        p0_re <= fft_real;
        p0_im <= fft_imag;
        p1_bin <= p0_bin;
        p1_first <= p0_first;
        p1_last <= p0_last;
        p1_a <= abs16(p0_re);
        p1_b <= abs16(p0_im);
        p2_bin <= p1_bin;
        p2_first <= p1_first;
        p2_last <= p1_last;
        p2_mag <= mag(p1_a, p1_b);
    end

    // the first frame of a group ignores whatever the RAM holds
    assign sum = (p2_first ? '0 : acc) + AW'(p2_mag);

    bin_accum_ram #(.DEPTH_LOG2(BINS_LOG2), .WIDTH(AW)) u_ram (
        .clk_data(clk_data),
        .wr_en(p2_v),
        .wr_addr(p2_bin),
        .wr_data(sum),
        .rd_addr(p1_bin),
        .rd_data(acc)
    );
endmodule

// File: tb/tb_waterfall_bin_averager.sv
// tb_waterfall_bin_averager: directed frames against a per-frame magnitude model
module tb_waterfall_bin_averager;
    logic clk_data = 1'b0, reset = 1'b1;
    logic fft_valid = 1'b0, fft_sop = 1'b0, fft_eop = 1'b0;
    logic signed [15:0] fft_real = '0, fft_imag = '0;
    logic sink_valid, sink_sop, sink_eop;
    logic [15:0] sink_data;
    logic [7:0] drop_count;

    waterfall_bin_averager dut (
        .clk_data(clk_data), .reset(reset), .fft_valid(fft_valid), .fft_sop(fft_sop),
        .fft_eop(fft_eop), .fft_real(fft_real), .fft_imag(fft_imag), .sink_valid(sink_valid),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_data(sink_data), .drop_count(drop_count)
    );

    always #5 clk_data = ~clk_data;

    typedef struct {int due; int data; bit sop; bit eop;} exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0, drop_m = 0, g_m = 0, idx_m = 0, last_sop_cyc = 0, bin_m = 0;
    bit in_frame = 0, tk, fin, bad, ev;
    int frames[4][512];
    int checks = 0, errors = 0;
    int got[512];
    int got_cnt = 0, sop_cnt = 0, eop_cnt = 0, lat = -1;

    function automatic int mag_of(int re, int im);
        int a = re < 0 ? -re : re;
        int b = im < 0 ? -im : im;
        return (a > b) ? a + b / 2 : b + a / 2;
    endfunction

    // model: frames of the current group kept whole; column = mean over the 4 frames
    always @(posedge clk_data) begin
        cyc++;
        if (reset) begin
            q.delete();
            in_frame = 0;
            g_m = 0;
            drop_m = 0;
            idx_m = 0;
        end else if (fft_valid) begin
            tk = 0; fin = 0; bad = 0; bin_m = idx_m;
            if (fft_sop) begin
                bad = in_frame;
                tk = 1;
                bin_m = 0;
                in_frame = 1;
                last_sop_cyc = cyc;
            end else if (in_frame) begin
                if (idx_m == 511) begin
                    if (fft_eop) begin tk = 1; fin = 1; end
                    else bad = 1;
                    in_frame = 0;
                end else if (fft_eop) begin
                    bad = 1;
                    in_frame = 0;
                end else tk = 1;
            end
            if (bad) begin
                g_m = 0;
                if (drop_m < 255) drop_m++;
            end
            if (tk) begin
                frames[g_m][bin_m] = mag_of(fft_real, fft_imag);
                if (g_m == 3)
                    q.push_back('{due: cyc + 3,
                                  data: (frames[0][bin_m] + frames[1][bin_m] + frames[2][bin_m] + frames[3][bin_m]) / 4,
                                  sop: bin_m == 0, eop: bin_m == 511});
                idx_m = bin_m + 1;
            end
            if (fin) g_m = (g_m + 1) % 4;
        end
    end

    always @(negedge clk_data) begin
        if (cyc > 0) begin
            ev = q.size() > 0 && q[0].due == cyc;
            checks++;
            if (sink_valid !== ev) begin
                errors++;
                $display("FAIL sink_valid cyc %0d got %b exp %b", cyc, sink_valid, ev);
            end
            if (ev) begin
                e = q.pop_front();
                checks++;
                if (sink_valid !== 1'b1 || sink_data !== e.data[15:0] || sink_sop !== e.sop || sink_eop !== e.eop) begin
                    errors++;
                    $display("FAIL column cyc %0d got data %0d sop %b eop %b exp data %0d sop %b eop %b",
                             cyc, sink_data, sink_sop, sink_eop, e.data, e.sop, e.eop);
                end
            end
            checks++;
            if (drop_count !== drop_m[7:0]) begin
                errors++;
                $display("FAIL drop_count cyc %0d got %0d exp %0d", cyc, drop_count, drop_m);
            end
            if (sink_valid === 1'b1) begin
                if (got_cnt == 0) lat = cyc - last_sop_cyc;
                if (got_cnt < 512) got[got_cnt] = sink_data;
                got_cnt++;
                sop_cnt += sink_sop;
                eop_cnt += sink_eop;
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, actual, expected);
        end
    endtask

    task automatic clear_log();
        got_cnt = 0; sop_cnt = 0; eop_cnt = 0; lat = -1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk_data);
        #1;
    endtask

    task automatic send(input int re, input int im, input bit sop, input bit eop, input bit gap);
        @(negedge clk_data);
        fft_valid = 1'b1; fft_sop = sop; fft_eop = eop;
        fft_real = 16'(re); fft_imag = 16'(im);
        @(posedge clk_data);
        #1;
        fft_valid = 1'b0; fft_sop = 1'b0; fft_eop = 1'b0;
        if (gap) @(posedge clk_data);
    endtask

    // kind 0: 100-40j, kind 1: ramp k*16*scale, kind 2: full-scale negative
    task automatic send_frame(input int kind, input int scale, input bit gap, input int n, input int eop_bin);
        int re, im;
        for (int k = 0; k < n; k++) begin
            re = kind == 0 ? 100 : kind == 1 ? k * 16 * scale : -32768;
            im = kind == 0 ? -40 : kind == 1 ? 0 : -32768;
            send(re, im, k == 0, k == eop_bin, gap);
        end
    endtask

    initial begin
        settle(3);
        chk("reset_valid", sink_valid, 0);
        chk("reset_sop", sink_sop, 0);
        chk("reset_data", sink_data, 0);
        chk("reset_drop", drop_count, 0);
        reset = 1'b0;
        settle(2);

        clear_log();
        for (int f = 0; f < 4; f++) send_frame(0, 1, 0, 512, 511);
        settle(6);
        chk("const_count", got_cnt, 512);
        chk("const_bin0", got[0], 120);
        chk("const_bin511", got[511], 120);
        chk("const_sops", sop_cnt, 1);
        chk("const_eops", eop_cnt, 1);
        chk("const_latency", lat, 3);

        clear_log();
        for (int f = 0; f < 4; f++) send_frame(1, f + 1, 0, 512, 511);
        settle(6);
        chk("ramp_bin0", got[0], 0);
        chk("ramp_bin1", got[1], 40);
        chk("ramp_bin511", got[511], 20440);

        clear_log();
        for (int f = 0; f < 4; f++) send_frame(2, 1, 0, 512, 511);
        settle(6);
        chk("extreme_bin0", got[0], 49152);
        chk("extreme_bin300", got[300], 49152);

        clear_log();
        send_frame(0, 1, 0, 512, 511);
        send_frame(0, 1, 0, 301, 300);
        settle(6);
        chk("abort_drop", drop_count, 1);
        chk("abort_no_output", got_cnt, 0);
        for (int f = 0; f < 4; f++) send_frame(0, 1, 0, 512, 511);
        settle(6);
        chk("abort_count", got_cnt, 512);
        chk("abort_bin5", got[5], 120);

        clear_log();
        for (int f = 0; f < 4; f++) send_frame(1, f + 1, 1, 512, 511);
        settle(8);
        chk("gap_count", got_cnt, 512);
        chk("gap_bin1", got[1], 40);
        chk("gap_bin511", got[511], 20440);
        chk("gap_latency", lat, 3);

        for (int f = 0; f < 3; f++) send_frame(0, 1, 0, 512, 511);
        send_frame(0, 1, 0, 200, -1);
        chk("pre_reset_valid", sink_valid, 1);
        @(negedge clk_data);
        reset = 1'b1;
        @(negedge clk_data);
        reset = 1'b0;
        settle(1);
        chk("post_reset_valid", sink_valid, 0);
        chk("post_reset_drop", drop_count, 0);
        clear_log();
        settle(5);
        chk("post_reset_quiet", got_cnt, 0);
        for (int f = 0; f < 4; f++) send_frame(0, 1, 0, 512, 511);
        settle(6);
        chk("reset_col_count", got_cnt, 512);
        chk("reset_col_bin0", got[0], 120);
        chk("reset_col_bin511", got[511], 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/waterfall_bin_averager.md
# waterfall_bin_averager

Upstream stage of the dual waterfall display, one instance per band (low/high). It consumes the FFT output stream, converts each complex bin to a 16-bit magnitude estimate, and averages 2^AVG_LOG2 consecutive spectra bin-by-bin. It emits one averaged spectrum column as the `sink_valid`/`sink_data` stream that feeds the waterfall's column framebuffer.

## Interface
Parameters:
- `BINS_LOG2`, default 9: log2 of the bin count per spectrum; default is 512 bins.
- `AVG_LOG2`, default 2: log2 of the number of spectra averaged per output column; 0 passes every frame through.

Ports:
- `clk_data` in 1: data clock; the only clock in this block.
- `reset` in 1: synchronous, active-high.
- `fft_valid` in 1: input sample strobe; no backpressure.
- `fft_sop` in 1: qualifies bin 0 of a spectrum; only meaningful with `fft_valid`.
- `fft_eop` in 1: qualifies the last bin of a spectrum.
- `fft_real` in 16: signed real part.
- `fft_imag` in 16: signed imaginary part.
- `sink_valid` out 1: averaged bin strobe.
- `sink_sop` out 1: marks averaged bin 0.
- `sink_eop` out 1: marks averaged bin 2^BINS_LOG2−1.
- `sink_data` out 16: averaged magnitude, unsigned.
- `drop_count` out 8: malformed-frame counter; saturates at 255.

## Operation
- Magnitude:
  - a = |fft_real|, b = |fft_imag|, both 16-bit unsigned; |−32768| = 32768.
  - mag = max(a,b) + (min(a,b) >> 1).
  - Maximum value is 49152, so 16 bits suffice and there is no saturation.
- FSM has two states, IDLE and FRAME.
  - IDLE: samples without sop are ignored. `fft_valid && fft_sop` sets bin index to 0 and moves to FRAME.
  - FRAME: each valid sample increments the bin index.
  - A valid sample at index 2^BINS_LOG2−1 with `fft_eop` is a good frame. The FSM returns to IDLE and the group counter g increments modulo 2^AVG_LOG2.
- Malformed frame:
  - Triggers: `fft_eop` before the last index, a missing `fft_eop` on the last index, or `fft_sop` in FRAME.
  - Response: `drop_count` increments and g resets to 0, so the whole averaging group is discarded.
  - A sop that causes the abort also starts a new frame at bin 0 with g=0.
- Accumulator RAM:
  - Depth 2^BINS_LOG2, width 16+AVG_LOG2.
  - g=0: write mag without reading, which overwrites stale contents.
  - 0<g<last: write acc+mag.
  - g=last: output (acc+mag) >> AVG_LOG2 as `sink_data`. The RAM write is don't-care.
- Output markers:
  - `sink_sop` is asserted on bin 0 and `sink_eop` on the last bin, both only in output frames.
  - An abort during an output frame stops output immediately and no `sink_eop` is produced.
- Arithmetic: all sums are unsigned, with no overflow by width choice.

## Timing
- Accepts one sample per cycle; gaps in `fft_valid` are allowed at any point.
- Fixed latency of 3 cycles from the sampling edge of an input to registered `sink_valid`:
  - stage 1: abs values, RAM read address;
  - stage 2: mag, RAM read data;
  - stage 3: sum, RAM write, output registers.
- `sink_sop`/`sink_eop` are pipelined alongside `sink_valid`.
- RAM has 1-cycle read latency. Adjacent samples hit distinct addresses, so no read/write forwarding is required.
- Reset values: `sink_valid`, `sink_sop`, `sink_eop` = 0; `sink_data` = 0; `drop_count` = 0; FSM = IDLE; g = 0; pipeline valids = 0. RAM contents are not reset.
- Reset asserted mid-frame:
  - in-flight pipeline samples are squashed;
  - no output appears in the cycles after reset;
  - the next sop starts a fresh group.

## Structure
- Package `waterfall_pkg` holds:
  - FSM state enum (IDLE, FRAME);
  - default `BINS_LOG2` and `AVG_LOG2`;
  - the mag function.
- Sub-module `bin_accum_ram` is a simple dual-port RAM, parameterised by depth and width, with registered read and one write port, all on `clk_data`.

## Test plan
- Four clean 512-bin frames, AVG_LOG2=2, every sample real=100, imag=−40:
  - mag = 100+20 = 120;
  - one output column of 512 samples, all `sink_data`=120;
  - `sink_sop` on the first, `sink_eop` on the last;
  - first `sink_valid` exactly 3 cycles after the 4th frame's sop.
- Frames with bin k carrying real=k·16 in frames 0–3, scaled by (1,2,3,4) per frame:
  - output bin k = (10·k·16)>>2;
  - spot-check k=0, 1, 511.
- Extreme inputs, real=−32768, imag=−32768 in all frames:
  - mag = 49152;
  - output 49152 with no wrap.
- Second frame of a group ends with eop at index 300:
  - `drop_count`=1;
  - the next four good frames produce exactly one correct column;
  - no output before that column.
- `fft_valid` deasserted every other cycle throughout:
  - identical output data to the gapless case;
  - latency 3 cycles per sample.
- Reset pulsed mid-frame during an output frame:
  - `sink_valid` drops;
  - the next four good frames yield a correct column;
  - `drop_count`=0 after reset.
